// File: rtl/riscv_div_issue_if.sv
// rtl/riscv_div_issue_if.sv - request/response and divider-side signals of the divider front-end
// Purpose: groups the EX-stage request port, the response port and the
//          serial-divider load/result handshake into one bundle.
// Modports: slave  - the front-end (riscv_div_issue)
//           master - the environment (EX stage + riscv_alu_div)
interface riscv_div_issue_if #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
);
  logic                   ReqVld_SI;
  logic                   ReqRdy_SO;
  logic [C_WIDTH-1:0]     ReqOpA_DI;
  logic [C_WIDTH-1:0]     ReqOpB_DI;
  logic [1:0]             ReqOpCode_SI;
  logic                   Flush_SI;
  logic                   RespVld_SO;
  logic                   RespRdy_SI;
  logic [C_WIDTH-1:0]     Resp_DO;
  logic                   Busy_SO;
  logic [C_WIDTH-1:0]     DivOpA_DO;
  logic [C_WIDTH-1:0]     DivOpB_DO;
  logic [C_LOG_WIDTH-1:0] DivOpBShift_DO;
  logic                   DivOpBIsZero_SO;
  logic                   DivOpBSign_SO;
  logic [1:0]             DivOpCode_SO;
  logic                   DivInVld_SO;
  logic                   DivOutRdy_SO;
  logic                   DivOutVld_SI;
  logic [C_WIDTH-1:0]     DivRes_DI;

  modport slave (
    input  ReqVld_SI, ReqOpA_DI, ReqOpB_DI, ReqOpCode_SI, Flush_SI, RespRdy_SI,
           DivOutVld_SI, DivRes_DI,
    output ReqRdy_SO, RespVld_SO, Resp_DO, Busy_SO, DivOpA_DO, DivOpB_DO,
           DivOpBShift_DO, DivOpBIsZero_SO, DivOpBSign_SO, DivOpCode_SO,
           DivInVld_SO, DivOutRdy_SO
  );

  modport master (
    output ReqVld_SI, ReqOpA_DI, ReqOpB_DI, ReqOpCode_SI, Flush_SI, RespRdy_SI,
           DivOutVld_SI, DivRes_DI,
    input  ReqRdy_SO, RespVld_SO, Resp_DO, Busy_SO, DivOpA_DO, DivOpB_DO,
           DivOpBShift_DO, DivOpBIsZero_SO, DivOpBSign_SO, DivOpCode_SO,
           DivInVld_SO, DivOutRdy_SO
  );
endinterface

// File: rtl/riscv_div_issue.sv
// rtl/riscv_div_issue.sv - issue front-end for the serial divider riscv_alu_div
// Purpose: accepts div/divu/rem/remu, normalises divisor B (leading-bit count
//          and pre-shift), loads the divider, captures its result and returns
//          it on a valid/ready response port; drains the divider on flush.
// Ports:   Clk_CI  - clock
//          Rst_RBI - asynchronous active-low reset
//          bus     - riscv_div_issue_if.slave (request, response, divider side)
module riscv_div_issue #(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input logic               Clk_CI,
  input logic               Rst_RBI,
  riscv_div_issue_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, PREP, ISSUE, WAIT, RESP, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [C_WIDTH-1:0]     a_q, b_q;
  logic [1:0]             op_q;
  logic [C_WIDTH-1:0]     div_opa_q, div_opb_q, resp_q;
  logic [C_LOG_WIDTH-1:0] shift_q;
  logic                   zero_q, sign_q;
  logic [1:0]             div_op_q;

  logic                   load_req, load_div, cap_res;
  logic                   req_rdy, resp_vld, in_vld, out_rdy;

  // Normalisation of the registered divisor.
  logic                   is_signed, b_neg, b_zero;
  logic [C_WIDTH-1:0]     b_scan;
  logic [C_LOG_WIDTH-1:0] lz, shift_n;

  always_comb begin
    is_signed = op_q[0];
    b_neg     = is_signed & b_q[C_WIDTH-1];
    b_zero    = (b_q == '0);
    // Leading copies of the sign bit become leading zeros after inversion.
    b_scan    = b_neg ? ~b_q : b_q;
    lz        = C_LOG_WIDTH'(C_WIDTH);
    for (int i = 0; i < C_WIDTH; i++) begin
      if (b_scan[i]) lz = C_LOG_WIDTH'(C_WIDTH - 1 - i);
    end
    // Signed keeps one sign bit in the MSB, hence one less shift.
    if (b_zero)         shift_n = C_LOG_WIDTH'(C_WIDTH - 1);
    else if (is_signed) shift_n = lz - C_LOG_WIDTH'(1);
    else                shift_n = lz;
  end

  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    load_div = 1'b0;
    cap_res  = 1'b0;
    req_rdy  = 1'b0;
    resp_vld = 1'b0;
    in_vld   = 1'b0;
    out_rdy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_rdy = ~bus.Flush_SI;
        if (bus.ReqVld_SI && !bus.Flush_SI) begin
          load_req = 1'b1;
          state_d  = PREP;
        end
      end
      PREP: begin
        if (bus.Flush_SI) state_d = IDLE;
        else begin
          load_div = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // The divider shows OutVld while idle, so that doubles as its ready.
        in_vld = bus.DivOutVld_SI & ~bus.Flush_SI;
        if (bus.Flush_SI)          state_d = IDLE;
        else if (bus.DivOutVld_SI) state_d = WAIT;
      end
      WAIT: begin
        out_rdy = bus.DivOutVld_SI;
        if (bus.DivOutVld_SI) begin
          // A flush coinciding with the result just discards it.
          if (bus.Flush_SI) state_d = IDLE;
          else begin
            cap_res = 1'b1;
            state_d = RESP;
          end
        end else if (bus.Flush_SI) begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        resp_vld = 1'b1;
        if (bus.Flush_SI || bus.RespRdy_SI) state_d = IDLE;
      end
      DRAIN: begin
        out_rdy = bus.DivOutVld_SI;
        if (bus.DivOutVld_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      div_opa_q <= '0;
      div_opb_q <= '0;
      shift_q   <= '0;
      zero_q    <= 1'b0;
      sign_q    <= 1'b0;
      div_op_q  <= '0;
      resp_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load_req) begin
        a_q  <= bus.ReqOpA_DI;
        b_q  <= bus.ReqOpB_DI;
        op_q <= bus.ReqOpCode_SI;
      end
      // Div* operands are only written here, so they stay put until capture.
      if (load_div) begin
        div_opa_q <= a_q;
        div_opb_q <= b_q << shift_n;
        shift_q   <= shift_n;
        zero_q    <= b_zero;
        sign_q    <= b_neg;
        div_op_q  <= op_q;
      end
      if (cap_res) resp_q <= bus.DivRes_DI;
    end
  end

  assign bus.ReqRdy_SO       = req_rdy;
  assign bus.RespVld_SO      = resp_vld;
  assign bus.Resp_DO         = resp_q;
  assign bus.Busy_SO         = (state_q != IDLE);
  assign bus.DivOpA_DO       = div_opa_q;
  assign bus.DivOpB_DO       = div_opb_q;
  assign bus.DivOpBShift_DO  = shift_q;
  assign bus.DivOpBIsZero_SO = zero_q;
  assign bus.DivOpBSign_SO   = sign_q;
  assign bus.DivOpCode_SO    = div_op_q;
  assign bus.DivInVld_SO     = in_vld;
  assign bus.DivOutRdy_SO    = out_rdy;

endmodule
